rsa_job_sequencer: RTL and testbench
====================================

RSA_JOB_SEQUENCER -- requirements
Module: rsa_job_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the RSA operand and result width in bits.
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning the number of operand/result slots; legal range 2..16.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum RUN cycles per channel before abort; TIMEOUT >= 2.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high: clk input 1, rising-edge clock.
REQ-005 rst input 1: synchronous active-high reset.
REQ-006 ena input 1: global enable; 0 freezes all state.
REQ-007 start input 1: single-cycle batch start command.
REQ-008 stop input 1: single-cycle abort command.
REQ-009 ch_mask input CHANNELS: channels to process, sampled on accepted start.
REQ-010 rsa_eoc input 1: end of conversion from the RSA unit.
REQ-011 rsa_c input WIDTH: RSA unit result.
REQ-012 irq_clr input 1: clears irq.
REQ-013 rsa_en output 1: RSA unit enable.
REQ-014 rsa_clear output 1: RSA unit clear pulse.
REQ-015 sel_ch output $clog2(CHANNELS): channel currently selected; drives the external operand mux.
REQ-016 res_data output WIDTH*CHANNELS: result registers, channel i at bits [i*WIDTH +: WIDTH].
REQ-017 done_mask output CHANNELS: sticky per-channel completion flags.
REQ-018 busy, irq, timeout_err, aborted outputs 1 each.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR and RUN.
REQ-020 busy SHALL be 1 exactly when the state is not IDLE.
REQ-021 In IDLE with start=1 and ch_mask!=0, the block SHALL latch ch_mask into pending, set sel_ch to the lowest set bit, clear done_mask, timeout_err and aborted, and go to CLEAR.
REQ-022 start with ch_mask==0 SHALL be ignored. start while busy SHALL be ignored.
REQ-023 In CLEAR, rsa_clear=1, rsa_en=0, the cycle timer resets to 0, and the next state SHALL be RUN.
REQ-024 rsa_clear SHALL be high for exactly one cycle per channel.
REQ-025 In RUN, rsa_en=1 and the timer SHALL increment every cycle.
REQ-026 In RUN with rsa_eoc=1, at that edge the block SHALL write rsa_c into res_data[sel_ch], set done_mask[sel_ch], and clear pending[sel_ch].
REQ-027 After REQ-026, if pending bits remain, sel_ch SHALL take the next-lowest pending index and the state SHALL go to CLEAR; otherwise the state SHALL go to IDLE and irq SHALL be set.
REQ-028 In RUN, if rsa_eoc=0 and the timer equals TIMEOUT-1, the block SHALL set timeout_err and irq, leave the remaining channels unprocessed, and go to IDLE.
REQ-029 On stop=1 in CLEAR or RUN, the block SHALL go to IDLE, set aborted and irq, and discard the result of the current channel.
REQ-030 stop in IDLE SHALL have no effect.
REQ-031 Same-cycle priority SHALL be: stop > rsa_eoc > timeout.
REQ-032 irq SHALL be a level signal cleared by irq_clr. If a set and irq_clr occur in the same cycle, the set SHALL win.
REQ-033 rsa_en and rsa_clear SHALL be 0 in IDLE.
REQ-034 sel_ch SHALL hold its last value in IDLE.
REQ-035 res_data for unprocessed channels SHALL retain their previous contents.
REQ-036 With ena=0, all registers SHALL hold, and rsa_en and rsa_clear SHALL be forced to 0.
REQ-037 Timing: start accepted at edge T gives rsa_clear high in cycle T+1, and rsa_en high from cycle T+2.

Reset
REQ-038 On rst=1 at a clock edge, the state SHALL become IDLE; pending, done_mask, res_data, sel_ch and the timer SHALL become 0; busy, irq, timeout_err, aborted, rsa_en and rsa_clear SHALL become 0.
REQ-039 rst SHALL take priority over ena and all commands.
REQ-040 rst mid-batch SHALL abort the batch without setting irq.

Verification
REQ-041 Single channel: ch_mask=0001, start; rsa_eoc with rsa_c=0x5A after 10 RUN cycles -> res_data[7:0]=0x5A, done_mask=0001, irq=1, busy=0.
REQ-042 Sparse mask: ch_mask=1010, eoc results 0x11 then 0x22 -> sel_ch sequence 1 then 3, two rsa_clear pulses, res_data ch1=0x11 and ch3=0x22, ch0 and ch2 unchanged.
REQ-043 Timeout: TIMEOUT=16, ch_mask=0011, no eoc -> after 16 RUN cycles timeout_err=1, irq=1, done_mask=0000, busy=0.
REQ-044 Same-cycle stop and eoc: stop and rsa_eoc asserted in the same cycle -> aborted=1, done_mask bit not set, result not written.
REQ-045 Irq race and ena freeze: irq_clr coincident with batch completion -> irq=1. ena=0 held 5 cycles mid-RUN -> timer, state and outputs frozen, rsa_en=0.
REQ-046 Mid-run reset: rst during RUN -> next cycle all outputs are 0 and a new start is accepted immediately.

Source files
------------

// File: rtl/rsa_job_sequencer.sv
// RSA job sequencer: walks the channels set in ch_mask in ascending order,
// pulsing rsa_clear and then enabling the RSA unit for each one, storing
// each result in its slot, and raising irq at the end of the batch.
module rsa_job_sequencer #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      start,
  input  logic                      stop,
  input  logic [CHANNELS-1:0]       ch_mask,
  input  logic                      rsa_eoc,
  input  logic [WIDTH-1:0]          rsa_c,
  input  logic                      irq_clr,
  output logic                      rsa_en,
  output logic                      rsa_clear,
  output logic [$clog2(CHANNELS)-1:0] sel_ch,
  output logic [WIDTH*CHANNELS-1:0] res_data,
  output logic [CHANNELS-1:0]       done_mask,
  output logic                      busy,
  output logic                      irq,
  output logic                      timeout_err,
  output logic                      aborted
);

  localparam int SW = $clog2(CHANNELS);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

  state_t                    state_q, state_d;
  logic [CHANNELS-1:0]       pending_q, pending_d;
  logic [CHANNELS-1:0]       done_q, done_d;
  logic [WIDTH*CHANNELS-1:0] res_q, res_d;
  logic [SW-1:0]             sel_q, sel_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      irq_q, irq_d;
  logic                      tmo_q, tmo_d;
  logic                      ab_q, ab_d;
  logic [CHANNELS-1:0]       rem_mask;

  // Index of the lowest set bit (0 when none is set).
  function automatic logic [SW-1:0] lowest(input logic [CHANNELS-1:0] m);
    logic [SW-1:0] idx;
    idx = '0;
    for (int unsigned i = CHANNELS; i > 0; i--) begin
      if (m[i-1]) idx = SW'(i - 1);
    end
    return idx;
  endfunction

  // Next-state and output decode; stop outranks eoc, eoc outranks timeout.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = done_q;
    res_d     = res_q;
    sel_d     = sel_q;
    timer_d   = timer_q;
    irq_d     = irq_q;
    tmo_d     = tmo_q;
    ab_d      = ab_q;
    rem_mask  = pending_q & ~(CHANNELS'(1) << sel_q);
    rsa_en    = 1'b0;
    rsa_clear = 1'b0;

    if (ena) begin
      if (irq_clr) irq_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start && (|ch_mask)) begin
            pending_d = ch_mask;
            sel_d     = lowest(ch_mask);
            done_d    = '0;
            tmo_d     = 1'b0;
            ab_d      = 1'b0;
            state_d   = CLEAR;
          end
        end
        CLEAR: begin
          rsa_clear = 1'b1;
          timer_d   = '0;
          if (stop) begin
            state_d   = IDLE;
            ab_d      = 1'b1;
            irq_d     = 1'b1;
            pending_d = '0;
          end else begin
            state_d = RUN;
          end
        end
        RUN: begin
          rsa_en  = 1'b1;
          timer_d = timer_q + TW'(1);
          if (stop) begin
            state_d   = IDLE;
            ab_d      = 1'b1;
            irq_d     = 1'b1;
            pending_d = '0;
          end else if (rsa_eoc) begin
            res_d[sel_q*WIDTH +: WIDTH] = rsa_c;
            done_d[sel_q]               = 1'b1;
            pending_d                   = rem_mask;
            if (|rem_mask) begin
              sel_d   = lowest(rem_mask);
              state_d = CLEAR;
            end else begin
              state_d = IDLE;
              irq_d   = 1'b1;
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_d   = IDLE;
            tmo_d     = 1'b1;
            irq_d     = 1'b1;
            pending_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= '0;
      res_q     <= '0;
      sel_q     <= '0;
      timer_q   <= '0;
      irq_q     <= 1'b0;
      tmo_q     <= 1'b0;
      ab_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      res_q     <= res_d;
      sel_q     <= sel_d;
      timer_q   <= timer_d;
      irq_q     <= irq_d;
      tmo_q     <= tmo_d;
      ab_q      <= ab_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign sel_ch      = sel_q;
  assign res_data    = res_q;
  assign done_mask   = done_q;
  assign irq         = irq_q;
  assign timeout_err = tmo_q;
  assign aborted     = ab_q;

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Scoreboard bench for rsa_job_sequencer.
module tb_rsa_job_sequencer;
  localparam int W  = 8;
  localparam int CH = 4;
  localparam int TO = 16;

  localparam int A_EOC   = 0;
  localparam int A_TMO   = 1;
  localparam int A_STOPR = 2;
  localparam int A_STOPC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ena, start, stop, rsa_eoc, irq_clr;
  logic [CH-1:0] ch_mask;
  logic [W-1:0]  rsa_c;
  logic          rsa_en, rsa_clear, busy, irq, timeout_err, aborted;
  logic [1:0]    sel_ch;
  logic [W*CH-1:0] res_data;
  logic [CH-1:0] done_mask;

  rsa_job_sequencer #(.WIDTH(W), .CHANNELS(CH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop),
    .ch_mask(ch_mask), .rsa_eoc(rsa_eoc), .rsa_c(rsa_c), .irq_clr(irq_clr),
    .rsa_en(rsa_en), .rsa_clear(rsa_clear), .sel_ch(sel_ch),
    .res_data(res_data), .done_mask(done_mask), .busy(busy), .irq(irq),
    .timeout_err(timeout_err), .aborted(aborted)
  );

  typedef struct {
    logic [CH-1:0]   done;
    logic [W*CH-1:0] res;
    logic            tmo;
    logic            ab;
  } batch_t;

  int     checks = 0;
  int     errors = 0;
  batch_t batch_q[$];
  int     sel_q[$];
  logic [W-1:0] exp_res[CH];
  bit     skip_fall = 1'b0;
  int     cur_ch = 0;
  logic   last_ab = 1'b0;
  logic   last_tmo = 1'b0;

  int           act[CH];
  int           dly[CH];
  logic [W-1:0] dat[CH];
  logic         both[CH];
  int           frz;

  task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a clear pulse or ends a batch.
  logic   busy_prev = 1'b0;
  batch_t mb;
  int     msel;
  always @(negedge clk) begin
    if (rsa_clear === 1'b1) begin
      if (sel_q.size() == 0) chk("unexpected_clear", 1, 0);
      else begin
        msel = sel_q.pop_front();
        chk("sel_on_clear", 64'(sel_ch), 64'(msel));
      end
    end
    if (!ena) begin
      chk("freeze_en_clr", {rsa_en, rsa_clear}, 0);
      chk("freeze_busy", busy, 1);
      chk("freeze_sel", 64'(sel_ch), 64'(cur_ch));
    end
    if (busy_prev && !busy && !skip_fall) begin
      if (batch_q.size() == 0) chk("unexpected_batch_end", 1, 0);
      else begin
        mb = batch_q.pop_front();
        chk("done_mask", done_mask, mb.done);
        chk("res_data", res_data, mb.res);
        chk("timeout_err", timeout_err, mb.tmo);
        chk("aborted", aborted, mb.ab);
        chk("irq_at_end", irq, 1);
        chk("en_clr_idle", {rsa_en, rsa_clear}, 0);
      end
    end
    busy_prev = busy;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_batch(input logic [CH-1:0] mask, input logic clr_end);
    int     chans[$];
    batch_t b;
    int     k;
    logic   last;
    for (int i = 0; i < CH; i++) if (mask[i]) chans.push_back(i);
    // Reference outcome: channels run in ascending order until one fails to finish.
    b.done = '0;
    b.tmo  = 1'b0;
    b.ab   = 1'b0;
    for (int p = 0; p < chans.size(); p++) begin
      k = chans[p];
      sel_q.push_back(k);
      if (act[p] == A_EOC) begin
        exp_res[k] = dat[p];
        b.done[k]  = 1'b1;
      end else begin
        if (act[p] == A_TMO) b.tmo = 1'b1;
        else b.ab = 1'b1;
        break;
      end
    end
    for (int i = 0; i < CH; i++) b.res[i*W +: W] = exp_res[i];
    batch_q.push_back(b);
    last_ab  = b.ab;
    last_tmo = b.tmo;

    start = 1'b1; ch_mask = mask; tick;
    start = 1'b0; ch_mask = CH'($urandom);
    for (int p = 0; p < chans.size(); p++) begin
      last   = (p == chans.size() - 1) || (act[p] != A_EOC);
      cur_ch = chans[p];
      if (act[p] == A_STOPC) begin
        stop = 1'b1; irq_clr = clr_end; tick;
        stop = 1'b0; irq_clr = 1'b0;
        break;
      end
      tick;
      if (frz > 0 && p == 0) begin
        ena = 1'b0;
        repeat (frz) tick;
        ena = 1'b1;
      end
      if (act[p] == A_TMO) begin
        for (int c = 1; c <= TO; c++) begin
          if (c == TO) irq_clr = clr_end;
          tick;
        end
        irq_clr = 1'b0;
        break;
      end
      for (int c = 1; c < dly[p]; c++) begin
        if (c == 1 && $urandom_range(0, 2) == 0) begin
          start = 1'b1; ch_mask = CH'($urandom_range(1, 15));
        end
        tick;
        start = 1'b0;
      end
      if (act[p] == A_STOPR) begin
        stop = 1'b1; rsa_eoc = both[p];
      end else begin
        rsa_eoc = 1'b1;
      end
      rsa_c = dat[p];
      if (last) irq_clr = clr_end;
      tick;
      stop = 1'b0; rsa_eoc = 1'b0; irq_clr = 1'b0; rsa_c = W'($urandom);
      if (act[p] != A_EOC) break;
    end
    tick;
    chk("idle_after_batch", busy, 0);
  endtask

  task automatic idle_pokes(input logic do_clr);
    stop = 1'b1; tick; stop = 1'b0;
    chk("stop_idle_busy", busy, 0);
    chk("stop_idle_aborted", aborted, last_ab);
    start = 1'b1; ch_mask = '0; tick; start = 1'b0;
    chk("zero_mask_busy", busy, 0);
    chk("irq_held", irq, 1);
    chk("tmo_held", timeout_err, last_tmo);
    if (do_clr) begin
      irq_clr = 1'b1; tick; irq_clr = 1'b0;
      chk("irq_clr", irq, 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_irq"}, irq, 0);
    chk({tag, "_flags"}, {timeout_err, aborted, rsa_en, rsa_clear}, 0);
    chk({tag, "_done"}, done_mask, 0);
    chk({tag, "_res"}, res_data, 0);
    chk({tag, "_sel"}, 64'(sel_ch), 0);
  endtask

  task automatic set_ch(input int p, input int a, input int d, input logic [W-1:0] v, input logic bo);
    act[p] = a; dly[p] = d; dat[p] = v; both[p] = bo;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; start = 1'b0; stop = 1'b0; rsa_eoc = 1'b0;
    irq_clr = 1'b0; ch_mask = '0; rsa_c = '0; frz = 0;
    for (int i = 0; i < CH; i++) exp_res[i] = '0;
    tick; tick;
    rst = 1'b0;
    chk_all_zero("reset");

    // Single channel, completion coincides with irq_clr.
    set_ch(0, A_EOC, 11, 8'h5A, 1'b0);
    run_batch(4'b0001, 1'b1);
    idle_pokes(1'b1);

    // Sparse mask.
    set_ch(0, A_EOC, 3, 8'h11, 1'b0);
    set_ch(1, A_EOC, 5, 8'h22, 1'b0);
    run_batch(4'b1010, 1'b0);
    idle_pokes(1'b1);

    // Timeout on first of two channels.
    set_ch(0, A_TMO, 1, 8'h00, 1'b0);
    run_batch(4'b0011, 1'b0);
    idle_pokes(1'b1);

    // Stop together with eoc.
    set_ch(0, A_STOPR, 4, 8'hEE, 1'b1);
    run_batch(4'b0001, 1'b0);
    idle_pokes(1'b1);

    // Enable freeze mid-RUN.
    frz = 5;
    set_ch(0, A_EOC, 6, 8'h3C, 1'b0);
    run_batch(4'b0100, 1'b0);
    frz = 0;
    idle_pokes(1'b0);

    // Stop during CLEAR.
    set_ch(0, A_STOPC, 1, 8'h00, 1'b0);
    run_batch(4'b1000, 1'b0);
    idle_pokes(1'b1);

    // eoc on the last permitted RUN cycle beats timeout.
    set_ch(0, A_EOC, TO, 8'h77, 1'b0);
    run_batch(4'b0010, 1'b1);
    idle_pokes(1'b0);

    // Reset mid-RUN, then an immediate new start.
    sel_q.push_back(2);
    start = 1'b1; ch_mask = 4'b0100; tick;
    start = 1'b0; tick; tick; tick;
    skip_fall = 1'b1; rst = 1'b1; tick; rst = 1'b0;
    for (int i = 0; i < CH; i++) exp_res[i] = '0;
    chk_all_zero("midrst");
    @(negedge clk); #1;
    skip_fall = 1'b0;
    set_ch(0, A_EOC, 2, 8'h9D, 1'b0);
    set_ch(1, A_EOC, 7, 8'h4B, 1'b0);
    run_batch(4'b0101, 1'b0);
    idle_pokes(1'b1);

    // Randomized batches.
    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < CH; p++) begin
        int r;
        r = $urandom_range(0, 11);
        set_ch(p, (r == 0) ? A_TMO : (r == 1) ? A_STOPR : (r == 2) ? A_STOPC : A_EOC,
               $urandom_range(1, TO), W'($urandom), 1'($urandom));
      end
      frz = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_batch(CH'($urandom_range(1, 15)), 1'($urandom));
      frz = 0;
      idle_pokes(1'($urandom));
    end

    tick; tick;
    chk("sel_queue_drained", 64'(sel_q.size()), 0);
    chk("batch_queue_drained", 64'(batch_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
